iter_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit, next to the single-cycle ALU in the execute stage.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_sign_fix.sv | 14 +
 rtl/iter_muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and op classification.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  always_comb begin
    y = neg ? (~a + W'(1)) : a;
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Bit-serial RV32M multiply/divide unit with valid/ready handshakes on both sides.
// One shared 2*XLEN accumulator holds the product or the remainder:quotient pair.
module iter_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opr;
  logic [2:0]        op_r;
  logic              neg_r;

  logic              a_sgn, b_sgn, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     add_sum, sub_trial;
  logic [2*XLEN-1:0] acc_step, fix_in, fixed;
  logic [XLEN-1:0]   fix_res;
  logic              accept;

  assign accept = (state == IDLE) && in_valid && !flush;

  always_comb begin
    a_sgn  = rs1[XLEN-1] && (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    b_sgn  = rs2[XLEN-1] && ((op == OP_MUL) || (op == OP_MULH) ||
                             (op == OP_DIV) || (op == OP_REM));
    // remainder takes the dividend's sign, everything else the product/quotient sign
    neg_in = (is_div(op) && op[1]) ? a_sgn : (a_sgn ^ b_sgn);

    div_zero = is_div(op) && (rs2 == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MIN_NEG) && (rs2 == '1);
    if (div_zero) special_res = op[1] ? rs1 : '1;
    else          special_res = op[1] ? '0 : rs1;
  end

  muldiv_sign_fix #(.W(XLEN)) u_fix_a (.neg(a_sgn), .a(rs1), .y(mag_a));
  muldiv_sign_fix #(.W(XLEN)) u_fix_b (.neg(b_sgn), .a(rs2), .y(mag_b));

  always_comb begin
    add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opr};
    sub_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opr};
    if (is_div(op_r)) begin
      // restoring step: keep the trial remainder only when it did not borrow
      if (!sub_trial[XLEN]) acc_step = {sub_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                  acc_step = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {add_sum, acc[XLEN-1:1]};
      else        acc_step = {1'b0, acc[2*XLEN-1:1]};
    end

    if (is_div(op_r)) fix_in = {{XLEN{1'b0}}, op_r[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]};
    else              fix_in = acc;
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_p (.neg(neg_r), .a(fix_in), .y(fixed));

  always_comb begin
    if (!is_div(op_r) && (op_r != OP_MUL)) fix_res = fixed[2*XLEN-1:XLEN];
    else                                   fix_res = fixed[XLEN-1:0];
  end

  // datapath: operands latched on accept, one iteration per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= op;
      neg_r <= neg_in;
      if (is_div(op)) begin
        opr <= mag_b;
        acc <= {{XLEN{1'b0}}, mag_a};
      end else begin
        opr <= mag_a;
        acc <= {{XLEN{1'b0}}, mag_b};
      end
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      res       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (div_zero || div_ovf) begin
              state     <= DONE;
              out_valid <= 1'b1;
              res       <= special_res;
            end else begin
              state <= CALC;
              cnt   <= CNTW'(XLEN - 1);
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNTW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          state     <= DONE;
          out_valid <= 1'b1;
          res       <= fix_res;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit: directed vector table, corner sequences
// and randomized operations against a plain-arithmetic reference model.
module tb_iter_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] res;
  logic            busy;

  int total = 0;
  int passed = 0;

  iter_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    int          sa, sb;
    longint      sp;
    logic [63:0] p;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); p = sp; r = p[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); p = sp; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && sb == -1) r = a;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && sb == -1) r = 32'd0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    if (o >= 3'd4 && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept cycle's edge as 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (out_valid !== 1'b1) check("out_valid_timeout", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] a, b, e;
    logic [2:0] o;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    vecs[14] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  {63'b0, in_ready},  64'd1);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_busy",      {63'b0, busy},      64'd0);
    check("reset_res",       {32'b0, res},       64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check($sformatf("vec%0d_res", i), {32'b0, res}, {32'b0, vecs[i].exp});
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      take();
      check($sformatf("vec%0d_ready_after_take", i), {63'b0, in_ready}, 64'd1);
      check($sformatf("vec%0d_res_cleared", i), {32'b0, res}, 64'd0);
    end

    // Backpressure: hold the result for 10 cycles
    issue(3'd5, 32'd100, 32'd7);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_res",       {32'b0, res},       64'd14);
      check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      check("bp_in_ready",  {63'b0, in_ready},  64'd0);
    end
    take();
    check("bp_in_ready_after", {63'b0, in_ready},  64'd1);
    check("bp_valid_after",    {63'b0, out_valid}, 64'd0);

    // Flush mid-CALC; in_valid asserted during the flush cycle must be ignored
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    check("pre_flush_busy", {63'b0, busy}, 64'd1);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready",  {63'b0, in_ready},  64'd1);
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    check("flush_busy",      {63'b0, busy},      64'd0);
    check("flush_res",       {32'b0, res},       64'd0);
    issue(3'd3, 32'd3, 32'd5);
    check("post_flush_in_ready", {63'b0, in_ready}, 64'd0);
    wait_valid(lat);
    check("post_flush_res", {32'b0, res}, 64'd0);
    check("post_flush_lat", 64'(lat), 64'd34);
    take();

    // Reset mid-CALC
    issue(3'd0, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready",  {63'b0, in_ready},  64'd1);
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_busy",      {63'b0, busy},      64'd0);
    check("midrst_res",       {32'b0, res},       64'd0);
    issue(3'd0, 32'd6, 32'd7);
    wait_valid(lat);
    check("post_rst_res", {32'b0, res}, 64'd42);
    take();

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        3: a = 32'($urandom_range(0, 300));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      e = model(o, a, b);
      issue(o, a, b);
      wait_valid(lat);
      check($sformatf("rnd%0d_op%0d_%h_%h_res", i, o, a, b), {32'b0, res}, {32'b0, e});
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(model_lat(o, a, b)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check($sformatf("rnd%0d_held", i), {32'b0, res}, {32'b0, e});
      take();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
